// File: rtl/matmul_controller_if.sv
// Control bus between the matmul sequencer (master) and the register file / MAC datapath (slave).
interface matmul_controller_if #(
  parameter int address_width = 4
);
  logic                     in_start;
  logic                     in_mac_done;
  logic [address_width-1:0] out_address;
  logic [1:0]               out_type;
  logic [1:0]               out_select_matrix;
  logic                     out_read_en;
  logic                     out_write_en;
  logic                     out_load_a;
  logic                     out_load_b;
  logic                     out_mac_start;
  logic                     out_busy;
  logic                     out_done;

  modport master (
    input  in_start, in_mac_done,
    output out_address, out_type, out_select_matrix, out_read_en, out_write_en,
           out_load_a, out_load_b, out_mac_start, out_busy, out_done
  );

  modport slave (
    output in_start, in_mac_done,
    input  out_address, out_type, out_select_matrix, out_read_en, out_write_en,
           out_load_a, out_load_b, out_mac_start, out_busy, out_done
  );
endinterface

// File: rtl/matmul_controller.sv
// Sequencer for C = A*B: walks (i,j), fetches row i of A and column j of B,
// kicks the dot-product unit and writes the result cell back. All outputs registered.
module matmul_controller #(
  parameter int size          = 4,
  parameter int address_width = 4
) (
  input logic                 in_clk,
  input logic                 in_reset,
  matmul_controller_if.master bus
);
  localparam int IW = (size > 1) ? $clog2(size) : 1;
  localparam logic [IW-1:0]            LAST   = IW'(size - 1);
  localparam logic [IW-1:0]            ONE_I  = IW'(1);
  localparam logic [address_width-1:0] ONE_A  = address_width'(1);
  localparam logic [address_width-1:0] SIZE_A = address_width'(size);

  localparam logic [1:0] T_CELL = 2'b00, T_ROW = 2'b01, T_COL = 2'b10;
  localparam logic [1:0] M_A = 2'b00, M_B = 2'b01, M_C = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LD_B, MAC_GO, MAC_WAIT, WR_C, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            i, j;
  logic [address_width-1:0] i_a, j_a;
  logic [address_width-1:0] address;
  logic [1:0]               acc_type, sel;
  logic                     read_en, write_en, load_a, load_b, mac_start, busy, done;

  assign i_a = address_width'(i);
  assign j_a = address_width'(j);

  // Outputs are loaded on the edge that enters a state, so they line up with that state.
  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      address   <= '0;
      acc_type  <= T_CELL;
      sel       <= M_A;
      read_en   <= 1'b0;
      write_en  <= 1'b0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      mac_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      address   <= '0;
      acc_type  <= T_CELL;
      sel       <= M_A;
      read_en   <= 1'b0;
      write_en  <= 1'b0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      mac_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b1;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bus.in_start) begin
            i        <= '0;
            j        <= '0;
            state    <= RD_A;
            busy     <= 1'b1;
            read_en  <= 1'b1;
            acc_type <= T_ROW;
          end
        end
        RD_A: begin
          state    <= RD_B;
          read_en  <= 1'b1;
          load_a   <= 1'b1;
          acc_type <= T_COL;
          sel      <= M_B;
          address  <= j_a;
        end
        RD_B: begin
          state  <= LD_B;
          load_b <= 1'b1;
        end
        LD_B: begin
          state     <= MAC_GO;
          mac_start <= 1'b1;
        end
        MAC_GO: state <= MAC_WAIT;
        MAC_WAIT: begin
          if (bus.in_mac_done) begin
            state    <= WR_C;
            write_en <= 1'b1;
            sel      <= M_C;
            address  <= i_a * SIZE_A + j_a;
          end
        end
        WR_C: begin
          if (j != LAST) begin
            j        <= j + ONE_I;
            state    <= RD_A;
            read_en  <= 1'b1;
            acc_type <= T_ROW;
            address  <= i_a * SIZE_A;
          end else begin
            j <= '0;
            if (i != LAST) begin
              i        <= i + ONE_I;
              state    <= RD_A;
              read_en  <= 1'b1;
              acc_type <= T_ROW;
              address  <= (i_a + ONE_A) * SIZE_A;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_address       = address;
  assign bus.out_type          = acc_type;
  assign bus.out_select_matrix = sel;
  assign bus.out_read_en       = read_en;
  assign bus.out_write_en      = write_en;
  assign bus.out_load_a        = load_a;
  assign bus.out_load_b        = load_b;
  assign bus.out_mac_start     = mac_start;
  assign bus.out_busy          = busy;
  assign bus.out_done          = done;
endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench for matmul_controller: expected reads/writes are queued at start,
// popped as the controller issues them; done latency checked against the cycle formula.
module tb_matmul_controller;
  localparam int SIZE = 2;
  localparam int AW   = 4;

  logic in_clk   = 1'b0;
  logic in_reset = 1'b0;
  logic mac_resp = 1'b0;
  logic mac_spur = 1'b0;

  matmul_controller_if #(.address_width(AW)) bus();

  matmul_controller #(.size(SIZE), .address_width(AW)) dut (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .bus      (bus)
  );

  assign bus.in_mac_done = mac_resp | mac_spur;

  always #5 in_clk = ~in_clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, mac_delay = 1, done_cnt = 0, last_done_edge = 0, ms_edge = 0;
  logic prev_ms = 1'b0;
  logic [7:0] rq[$];
  logic [7:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.out_address, bus.out_type, bus.out_select_matrix, bus.out_read_en,
                bus.out_write_en, bus.out_load_a, bus.out_load_b, bus.out_mac_start,
                bus.out_busy, bus.out_done});
  endfunction

  initial forever begin
    @(posedge in_clk);
    cyc++;
  end

  // dot-product unit model: done arrives after mac_delay MAC_WAIT cycles
  initial forever begin
    @(negedge in_clk);
    if (bus.out_mac_start) begin
      repeat (mac_delay) @(negedge in_clk);
      mac_resp = 1'b1;
      @(negedge in_clk);
      mac_resp = 1'b0;
    end
  end

  // monitor / scoreboard
  initial forever begin
    logic [7:0] e;
    @(negedge in_clk);
    if (bus.out_read_en | bus.out_write_en)
      chk("rd_wr_excl", 32'(bus.out_read_en & bus.out_write_en), 0);
    if (bus.out_busy) chk("sel_legal", 32'(bus.out_select_matrix != 2'b11), 1);
    if (bus.out_mac_start) begin
      chk("ms_pulse", 32'(prev_ms), 0);
      ms_edge = cyc;
    end
    prev_ms = bus.out_mac_start;
    if (bus.out_load_b) chk("ldb_no_rd", 32'(bus.out_read_en), 0);
    if (bus.out_read_en) begin
      chk("rd_pending", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("rd_access", 32'({bus.out_address, bus.out_type, bus.out_select_matrix}), 32'(e));
        chk("load_a", 32'(bus.out_load_a), 32'(bus.out_type == 2'b10));
      end
    end
    if (bus.out_write_en) begin
      chk("wr_pending", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_access", 32'({bus.out_address, bus.out_type, bus.out_select_matrix}), 32'(e));
      end
      chk("mac_wait_len", 32'(cyc - ms_edge - 1), 32'(mac_delay));
    end
    if (bus.out_done) begin
      done_cnt++;
      last_done_edge = cyc;
    end
  end

  task automatic push_expect();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        rq.push_back({AW'(i * SIZE), 2'b01, 2'b00});
        rq.push_back({AW'(j), 2'b10, 2'b01});
        wq.push_back({AW'(i * SIZE + j), 2'b00, 2'b10});
      end
  endtask

  task automatic run_op(input int delay, input bit repulse, input bit spur, input int exp_cycles);
    int start_edge, d0, rp;
    bit got;
    mac_delay = delay;
    push_expect();
    if (spur) begin
      mac_spur = 1'b1;
      @(negedge in_clk); #1;
      mac_spur = 1'b0;
    end
    bus.in_start = 1'b1;
    @(negedge in_clk); #1;
    bus.in_start = 1'b0;
    start_edge = cyc;
    if (spur) begin
      mac_spur = 1'b1;
      @(negedge in_clk); #1;
      mac_spur = 1'b0;
    end
    d0 = done_cnt;
    got = 1'b0;
    rp = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge in_clk); #1;
      if (repulse) begin
        if (bus.out_mac_start) rp = 3;
        bus.in_start = (rp > 0);
        if (rp > 0) rp--;
      end
      if (done_cnt != d0) got = 1'b1;
    end
    bus.in_start = 1'b0;
    chk("done_seen", 32'(got), 1);
    if (got) chk("done_latency", 32'(last_done_edge - start_edge + 2), 32'(exp_cycles));
    chk("rq_drained", 32'(rq.size()), 0);
    chk("wq_drained", 32'(wq.size()), 0);
    @(negedge in_clk); #1;
    chk("post_done_idle", outs(), 0);
    rq.delete();
    wq.delete();
  endtask

  initial begin
    int d0;
    bit found;
    bus.in_start = 1'b0;
    repeat (3) @(negedge in_clk);
    #1;
    chk("reset_outs", outs(), 0);
    bus.in_start = 1'b1;
    @(negedge in_clk); #1;
    bus.in_start = 1'b0;
    in_reset = 1'b1;
    repeat (3) @(negedge in_clk);
    #1;
    chk("start_in_reset_ignored", outs(), 0);

    run_op(1, 1'b0, 1'b0, SIZE * SIZE * 6 + 2);
    run_op(5, 1'b0, 1'b0, SIZE * SIZE * 10 + 2);
    run_op(3, 1'b1, 1'b0, SIZE * SIZE * 8 + 2);
    run_op(1, 1'b0, 1'b1, SIZE * SIZE * 6 + 2);

    // abort during the write of element (1,0)
    mac_delay = 1;
    push_expect();
    bus.in_start = 1'b1;
    @(negedge in_clk); #1;
    bus.in_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge in_clk); #1;
      if (bus.out_write_en && bus.out_address == AW'(SIZE)) found = 1'b1;
    end
    chk("abort_point_reached", 32'(found), 1);
    d0 = done_cnt;
    in_reset = 1'b0;
    @(negedge in_clk); #1;
    chk("abort_outs", outs(), 0);
    in_reset = 1'b1;
    rq.delete();
    wq.delete();
    repeat (10) @(negedge in_clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_idle", outs(), 0);
    run_op(1, 1'b0, 1'b0, SIZE * SIZE * 6 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
